intr_sched: RTL and testbench

Interrupt scheduler for the pipelined CPU. It sits between the external interrupt sources and the CP0 register block. It latches and synchronises three request lines and arbitrates them by fixed priority against the current CP0 interrupt-enable and mask. It also tracks nested in-service levels, and sequences the pipeline break so that CP0 captures the EPC exactly once per accepted interrupt.

---
 rtl/intr_sched_pkg.sv | 26 ++
 rtl/intr_sched_if.sv | 27 ++
 rtl/irq_sync_edge.sv | 21 ++
 rtl/intr_sched.sv | 115 +++++++++++
 tb/tb_intr_sched.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/intr_sched_pkg.sv
// Shared types for the interrupt scheduler: FSM encoding, source codes and
// the priority encoder used for both request arbitration and in-service lookup.
package intr_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_BREAK = 2'd2
  } state_e;

  typedef logic [1:0] code_t;

  localparam code_t CODE_NONE = 2'd0;
  localparam code_t CODE_1    = 2'd1;
  localparam code_t CODE_2    = 2'd2;
  localparam code_t CODE_3    = 2'd3;

  // Highest set bit wins; bit i-1 corresponds to source code i.
  function automatic code_t prio_enc(input logic [2:0] req);
    if (req[2])      return CODE_3;
    else if (req[1]) return CODE_2;
    else if (req[0]) return CODE_1;
    else             return CODE_NONE;
  endfunction

endpackage

// File: rtl/intr_sched_if.sv
// Signal bundle between the CPU/CP0 side (master) and the interrupt scheduler (slave).
interface intr_sched_if;
  import intr_sched_pkg::*;

  logic [2:0]  in_IRQ;
  logic        in_IE;
  logic [3:0]  in_INM;
  logic        in_eret;
  logic        in_stall;
  logic        out_BK;
  logic        out_NIE;
  code_t       out_code;
  logic [31:0] out_vector;
  logic [2:0]  out_pending;
  logic [2:0]  out_isr;

  modport master (
    output in_IRQ, in_IE, in_INM, in_eret, in_stall,
    input  out_BK, out_NIE, out_code, out_vector, out_pending, out_isr
  );

  modport slave (
    input  in_IRQ, in_IE, in_INM, in_eret, in_stall,
    output out_BK, out_NIE, out_code, out_vector, out_pending, out_isr
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus an edge flop; rise_o pulses for one cycle on a
// rising edge of the synchronised request.
module irq_sync_edge (
  input  logic in_CLK,
  input  logic in_RST,
  input  logic irq_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], irq_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/intr_sched.sv
// Fixed-priority interrupt scheduler: latches request edges, arbitrates against
// IE/mask and nesting level, drains the pipeline, then issues a one-cycle break.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040,
  parameter int unsigned DRAIN_CYC  = 2
) (
  input  logic         in_CLK,
  input  logic         in_RST,
  intr_sched_if.slave  bus
);

  logic [2:0] rise;

  for (genvar i = 0; i < 3; i++) begin : g_sync
    irq_sync_edge u_sync (
      .in_CLK (in_CLK),
      .in_RST (in_RST),
      .irq_i  (bus.in_IRQ[i]),
      .rise_o (rise[i])
    );
  end

  state_e     state_q, state_d;
  code_t      cur_code_q, cur_code_d;
  code_t      code_q, code_d;
  logic [2:0] drain_q, drain_d;
  logic [2:0] pending_q, pending_d;
  logic [2:0] isr_q, isr_d;

  logic [2:0] eligible;
  code_t      best;
  logic       take;
  logic       cur_blocked;
  logic       brk;
  logic [3:0] cur_dec;
  logic [3:0] isr_top_dec;

  assign eligible    = pending_q & ~bus.in_INM[3:1] & {3{bus.in_IE}};
  assign best        = prio_enc(eligible);
  assign take        = best > prio_enc(isr_q);
  assign cur_blocked = ~bus.in_IE | bus.in_INM[cur_code_q];
  assign brk         = (state_q == S_BREAK);
  assign cur_dec     = 4'b0001 << cur_code_q;
  // Bit 0 of the decode stands for "no isr set", so an eret with isr==0 is a no-op.
  assign isr_top_dec = 4'b0001 << prio_enc(isr_q);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    drain_d    = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          cur_code_d = best;
          drain_d    = 3'(DRAIN_CYC);
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cur_blocked) begin
          state_d = S_IDLE;
        end else if (!bus.in_stall) begin
          drain_d = drain_q - 3'd1;
          if (drain_q == 3'd1) state_d = S_BREAK;
        end
      end
      S_BREAK:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    code_d = (state_d == S_BREAK) ? cur_code_q : CODE_NONE;
  end

  // Eret clears before break sets; a fresh edge beats the break's pending clear.
  always_comb begin
    isr_d     = isr_q;
    pending_d = pending_q;
    if (bus.in_eret) isr_d = isr_d & ~isr_top_dec[3:1];
    if (brk) begin
      isr_d     = isr_d | cur_dec[3:1];
      pending_d = pending_d & ~cur_dec[3:1];
    end
    pending_d = pending_d | rise;
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state_q    <= S_IDLE;
      cur_code_q <= CODE_NONE;
      code_q     <= CODE_NONE;
      drain_q    <= '0;
      pending_q  <= '0;
      isr_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      code_q     <= code_d;
      drain_q    <= drain_d;
      pending_q  <= pending_d;
      isr_q      <= isr_d;
    end
  end

  assign bus.out_BK      = brk;
  assign bus.out_NIE     = ~brk;
  assign bus.out_code    = code_q;
  assign bus.out_vector  = VEC_BASE + 32'(cur_code_q) * VEC_STRIDE;
  assign bus.out_pending = pending_q;
  assign bus.out_isr     = isr_q;

endmodule

// File: tb/tb_intr_sched.sv
// Directed bench for intr_sched: single request, mask/enable, nesting, stall,
// abort, simultaneous requests, eret/break collision and asynchronous reset.
module tb_intr_sched;
  import intr_sched_pkg::*;

  logic in_CLK = 1'b0;
  logic in_RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  intr_sched_if bus ();

  intr_sched #(
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0040),
    .DRAIN_CYC  (2)
  ) dut (
    .in_CLK (in_CLK),
    .in_RST (in_RST),
    .bus    (bus)
  );

  always #5 in_CLK = ~in_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_CLK);
    #1;
  endtask

  // The pulse's own tick is edge k; a break is then visible after edge k+5.
  task automatic pulse(input logic [2:0] bits);
    bus.in_IRQ = bits;
    tick();
    bus.in_IRQ = 3'b000;
  endtask

  task automatic do_eret();
    bus.in_eret = 1'b1;
    tick();
    bus.in_eret = 1'b0;
  endtask

  task automatic expect_break(input string tag, input code_t code, input int lat);
    int seen;
    seen = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.out_BK === 1'b1) begin
        seen = i;
        break;
      end
    end
    check({tag, "_lat"},  32'(seen), 32'(lat));
    check({tag, "_code"}, 32'(bus.out_code), 32'(code));
    check({tag, "_nie"},  32'(bus.out_NIE), 32'd0);
    check({tag, "_vec"},  bus.out_vector, 32'h100 + 32'(code) * 32'h40);
  endtask

  task automatic expect_no_break(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.out_BK !== 1'b0 || bus.out_code !== CODE_NONE) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    bus.in_IRQ   = 3'b000;
    bus.in_IE    = 1'b1;
    bus.in_INM   = 4'b0000;
    bus.in_eret  = 1'b0;
    bus.in_stall = 1'b0;

    #3;
    check("rst_bk",   32'(bus.out_BK), 32'd0);
    check("rst_nie",  32'(bus.out_NIE), 32'd1);
    check("rst_code", 32'(bus.out_code), 32'd0);
    check("rst_vec",  bus.out_vector, 32'h0000_0100);
    check("rst_pend", 32'(bus.out_pending), 32'd0);
    check("rst_isr",  32'(bus.out_isr), 32'd0);
    tick();
    tick();
    in_RST = 1'b0;
    tick();

    // Single request on source 1.
    pulse(3'b001);
    expect_break("single", CODE_1, 5);
    tick();
    check("single_isr",   32'(bus.out_isr), 32'b001);
    check("single_pend",  32'(bus.out_pending), 32'b000);
    check("single_codez", 32'(bus.out_code), 32'd0);
    check("single_bkz",   32'(bus.out_BK), 32'd0);
    do_eret();
    check("single_eret", 32'(bus.out_isr), 32'b000);

    // Masked source 2 waits in pending until the mask clears.
    bus.in_INM = 4'b0100;
    pulse(3'b010);
    expect_no_break("mask_hold", 8);
    check("mask_pend", 32'(bus.out_pending), 32'b010);
    bus.in_INM = 4'b0000;
    expect_break("mask_rel", CODE_2, 3);
    tick();
    do_eret();

    // Global enable low holds source 2 off.
    bus.in_IE = 1'b0;
    pulse(3'b010);
    expect_no_break("ie_hold", 8);
    check("ie_pend", 32'(bus.out_pending), 32'b010);
    bus.in_IE = 1'b1;
    expect_break("ie_rel", CODE_2, 3);
    tick();
    check("ie_isr", 32'(bus.out_isr), 32'b010);
    do_eret();
    check("ie_eret", 32'(bus.out_isr), 32'b000);

    // Nesting: code 3 preempts in-service code 1; a second code 1 must wait.
    pulse(3'b001);
    expect_break("nest1", CODE_1, 5);
    tick();
    pulse(3'b100);
    expect_break("nest3", CODE_3, 5);
    tick();
    check("nest_isr", 32'(bus.out_isr), 32'b101);
    pulse(3'b001);
    expect_no_break("nest_block", 8);
    check("nest_pend", 32'(bus.out_pending), 32'b001);
    do_eret();
    check("nest_eret1", 32'(bus.out_isr), 32'b001);
    expect_no_break("nest_still", 4);
    do_eret();
    check("nest_eret2", 32'(bus.out_isr), 32'b000);
    expect_break("nest_late1", CODE_1, 3);
    tick();
    do_eret();

    // Stall during DRAIN freezes the drain counter for exactly 4 cycles.
    pulse(3'b010);
    tick();
    tick();
    tick();
    bus.in_stall = 1'b1;
    expect_no_break("stall_hold", 4);
    bus.in_stall = 1'b0;
    expect_break("stall_rel", CODE_2, 2);
    tick();
    do_eret();

    // IE drop mid-DRAIN aborts without clearing pending.
    pulse(3'b010);
    tick();
    tick();
    tick();
    bus.in_IE = 1'b0;
    tick();
    check("abort_pend", 32'(bus.out_pending), 32'b010);
    expect_no_break("abort_hold", 6);
    bus.in_IE = 1'b1;
    expect_break("abort_rel", CODE_2, 3);
    tick();
    do_eret();

    // All three sources at once: serviced 3, then 2, then 1.
    pulse(3'b111);
    expect_break("sim3", CODE_3, 5);
    tick();
    check("sim_isr3",  32'(bus.out_isr), 32'b100);
    check("sim_pend3", 32'(bus.out_pending), 32'b011);
    do_eret();
    expect_break("sim2", CODE_2, 3);
    tick();
    check("sim_isr2", 32'(bus.out_isr), 32'b010);
    do_eret();
    expect_break("sim1", CODE_1, 3);
    tick();
    do_eret();
    check("sim_isr0",  32'(bus.out_isr), 32'b000);
    check("sim_pend0", 32'(bus.out_pending), 32'b000);

    // Eret in the BREAK cycle: clear of code 1 happens before set of code 3.
    pulse(3'b001);
    expect_break("coll1", CODE_1, 5);
    tick();
    pulse(3'b100);
    expect_break("coll3", CODE_3, 5);
    bus.in_eret = 1'b1;
    tick();
    bus.in_eret = 1'b0;
    check("coll_isr", 32'(bus.out_isr), 32'b100);
    do_eret();
    check("coll_eret", 32'(bus.out_isr), 32'b000);
    do_eret();
    check("eret_idle", 32'(bus.out_isr), 32'b000);

    // Asynchronous reset in the middle of DRAIN.
    pulse(3'b001);
    tick();
    tick();
    tick();
    #2 in_RST = 1'b1;
    #1;
    check("arst_nie",  32'(bus.out_NIE), 32'd1);
    check("arst_bk",   32'(bus.out_BK), 32'd0);
    check("arst_vec",  bus.out_vector, 32'h0000_0100);
    check("arst_pend", 32'(bus.out_pending), 32'b000);
    check("arst_isr",  32'(bus.out_isr), 32'b000);
    #2 in_RST = 1'b0;
    expect_no_break("arst_nobk", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
